data_out_port: RTL and testbench
================================

DATA_OUT_PORT -- requirements
Module: data_out_port

Interface
REQ-001 Parameter DEPTH, default 4, output buffer entries; SHALL be a power of two, 2..8.
REQ-002 Parameter WIDTH, default 8, data width of bus and port.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-high.
REQ-005 In_Bus  input  WIDTH  W-bus value to be written to the port.
REQ-006 L  input  1  load strobe; a write is requested when L=1 at a rising clk edge.
REQ-007 E  input  1  status enable; drives the status byte onto Out_Bus.
REQ-008 Out_Bus  output  WIDTH  tri-state status output; SHALL be high-Z whenever E=0.
REQ-009 Data_Out  output  WIDTH  byte presented to the external device.
REQ-010 Valid  output  1  Data_Out holds a new byte.
REQ-011 Ack  input  1  external device acknowledge (four-phase handshake).

Function
REQ-012 FIFO of DEPTH entries SHALL hold bytes written from In_Bus in arrival order; count range 0..DEPTH.
REQ-013 Edge with L=1 and count<DEPTH before the edge SHALL push In_Bus.
REQ-014 Edge with L=1 and count=DEPTH before the edge SHALL drop the byte and set sticky overflow, even if a pop occurs on the same edge.
REQ-015 Handshake FSM states: IDLE, SEND, RELEASE.
REQ-016 IDLE: if count>0 before the edge, pop head into Data_Out, Valid<=1, go to SEND; else stay.
REQ-017 SEND: hold Data_Out and Valid=1 until Ack=1 at an edge; then Valid<=0, go to RELEASE.
REQ-018 RELEASE: stay while Ack=1; when Ack=0 at an edge, go to IDLE.
REQ-019 Minimum latency: push at edge n SHALL give Valid=1 after edge n+1 when FSM is IDLE and FIFO empty.
REQ-020 Simultaneous push and pop SHALL both take effect; count unchanged.
REQ-021 Data_Out SHALL keep the last sent byte after Valid falls, until the next pop.
REQ-022 Ack=1 in IDLE SHALL be ignored; a pop in IDLE SHALL NOT occur until Ack=0 has been seen in RELEASE.
REQ-023 FIFO read/write pointers SHALL wrap modulo DEPTH.
REQ-024 Status byte (combinational): bit7 overflow, bit6 full, bit5 empty, bit4 busy (FSM != IDLE), bits3:0 count.
REQ-025 Edge with E=1 SHALL clear overflow; if an overflow occurs on the same edge, set wins.
REQ-026 L and E may be asserted together; Out_Bus SHALL show pre-edge status.

Reset
REQ-027 clr=1 SHALL immediately and asynchronously force FIFO count 0, pointers 0, overflow 0, FSM IDLE, Valid 0, Data_Out 0.
REQ-028 clr mid-handshake SHALL abort the transfer; queued bytes are discarded.
REQ-029 Out_Bus SHALL still obey E during reset (status 8'h20 when E=1).

Structure
REQ-030 Shared package data_out_pkg SHALL hold FSM state encoding, default DEPTH/WIDTH, status bit positions.
REQ-031 FIFO storage and pointers SHALL be one sub-module, out_fifo; FSM, status and tri-state in data_out_port.

Verification
REQ-032 clr, then L=1 with In_Bus=8'h3C for one edge -> Valid=1 with Data_Out=8'h3C one edge later; Ack=1 -> Valid=0 next edge.
REQ-033 Write 8'h01..8'h05 back-to-back with Ack held 0 -> first byte presented, 8'h01 popped, 8'h02..8'h05 buffered, no overflow; one more write -> overflow=1, dropped; handshakes deliver 8'h01..8'h05 in order.
REQ-034 Ack held 1 for 3 cycles after Valid falls -> FSM stays RELEASE, next byte not presented until after Ack=0.
REQ-035 E=1 with FIFO 2 deep, busy, overflow set -> Out_Bus=8'h92; next edge overflow cleared -> 8'h12; E=0 -> Out_Bus=8'hzz.
REQ-036 Assert clr asynchronously while Valid=1 -> Valid, Data_Out, count 0 without a clk edge; status 8'h20.
REQ-037 Run 20 writes interleaved with handshakes -> pointer wrap, output sequence equals input sequence.

Source files
------------

// File: rtl/data_out_pkg.sv
// Shared definitions for the buffered output port: default sizes, handshake
// state encoding and bit positions inside the status byte.
package data_out_pkg;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_RELEASE = 2'd2
  } hs_state_e;

  localparam int ST_OVF_BIT   = 7;
  localparam int ST_FULL_BIT  = 6;
  localparam int ST_EMPTY_BIT = 5;
  localparam int ST_BUSY_BIT  = 4;
  localparam int ST_CNT_W     = 4;
endpackage

// File: rtl/data_out_port_if.sv
// Write-side bus and device-side handshake of the output port.
interface data_out_port_if import data_out_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) ();
  logic [WIDTH-1:0] In_Bus;
  logic             L;
  logic             E;
  logic             Ack;
  logic [WIDTH-1:0] Data_Out;
  logic             Valid;

  modport master (output In_Bus, L, E, Ack, input  Data_Out, Valid);
  modport slave  (input  In_Bus, L, E, Ack, output Data_Out, Valid);
endinterface

// File: rtl/out_fifo.sv
// DEPTH-entry FIFO; pointers wrap naturally because DEPTH is a power of two.
module out_fifo import data_out_pkg::*; #(
  parameter  int DEPTH = DEF_DEPTH,
  parameter  int WIDTH = DEF_WIDTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        push_ok, pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push_ok) begin
      mem_d[wr_q] = wdata;
      wr_d        = wr_q + 1'b1;
    end
    if (pop_ok) rd_d = rd_q + 1'b1;
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/data_out_port.sv
// Buffered output port: FIFO feeding a four-phase Valid/Ack handshake, with a
// tri-state status byte readable on Out_Bus while E is high.
module data_out_port import data_out_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  data_out_port_if.slave   bus,
  output wire  [WIDTH-1:0] Out_Bus
);
  localparam int CW = $clog2(DEPTH + 1);

  hs_state_e        state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             pop, full, empty;
  logic [WIDTH-1:0] head;
  logic [CW-1:0]    count;
  logic [7:0]       status;

  out_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
    .clk   (clk),
    .rst   (clr),
    .push  (bus.L),
    .wdata (bus.In_Bus),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: if (!empty) begin
        pop     = 1'b1;
        dout_d  = head;
        valid_d = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: if (bus.Ack) begin
        valid_d = 1'b0;
        state_d = ST_RELEASE;
      end
      ST_RELEASE: if (!bus.Ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A write that finds the FIFO full is lost even if a pop frees a slot on the same edge.
    ovf_d = ovf_q;
    if (bus.L && full) ovf_d = 1'b1;
    else if (bus.E)    ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    status                           = '0;
    status[ST_OVF_BIT]               = ovf_q;
    status[ST_FULL_BIT]              = full;
    status[ST_EMPTY_BIT]             = empty;
    status[ST_BUSY_BIT]              = (state_q != ST_IDLE);
    status[ST_CNT_W-1:0]             = ST_CNT_W'(count);
  end

  assign bus.Data_Out = dout_q;
  assign bus.Valid    = valid_q;
  assign Out_Bus      = bus.E ? WIDTH'(status) : {WIDTH{1'bz}};
endmodule

// File: tb/tb_data_out_port.sv
// Directed and randomized checks of data_out_port against a queue-based model
// of the FIFO and the Valid/Ack handshake.
module tb_data_out_port;
  localparam int DEPTH = 4;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic clr = 1'b0;
  tri1 [WIDTH-1:0] out_bus;  // pulled high so a released bus reads as all ones

  data_out_port_if #(.WIDTH(WIDTH)) bi ();

  data_out_port #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .clr     (clr),
    .bus     (bi),
    .Out_Bus (out_bus)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model
  logic [7:0] q[$];
  logic [7:0] accepted[$];
  logic [7:0] delivered[$];
  bit         presenting, releasing, movf, prev_v;
  logic [7:0] mdout;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_status();
    logic [7:0] s;
    s[7]   = movf;
    s[6]   = (q.size() == DEPTH);
    s[5]   = (q.size() == 0);
    s[4]   = presenting || releasing;
    s[3:0] = 4'(q.size());
    return s;
  endfunction

  task automatic model_reset();
    q.delete(); accepted.delete(); delivered.delete();
    presenting = 0; releasing = 0; movf = 0; mdout = '0; prev_v = 0;
  endtask

  task automatic drive(bit l, logic [7:0] d, bit e, bit a);
    @(negedge clk);
    bi.L = l; bi.In_Bus = d; bi.E = e; bi.Ack = a;
    #1;
    chk("out_bus", 32'(out_bus), e ? 32'(model_status()) : 32'hFF);
  endtask

  task automatic tick();
    bit was_full;
    @(posedge clk);
    was_full = (q.size() == DEPTH);
    if (!presenting && !releasing && q.size() > 0) begin
      mdout = q.pop_front();
      presenting = 1;
    end else if (presenting && bi.Ack) begin
      presenting = 0; releasing = 1;
    end else if (releasing && !bi.Ack) begin
      releasing = 0;
    end
    if (bi.L && !was_full) begin
      q.push_back(bi.In_Bus);
      accepted.push_back(bi.In_Bus);
    end
    if (bi.L && was_full) movf = 1;
    else if (bi.E)        movf = 0;
    #1;
    chk("valid", 32'(bi.Valid), 32'(presenting));
    chk("data_out", 32'(bi.Data_Out), 32'(mdout));
    if (bi.Valid && !prev_v) delivered.push_back(bi.Data_Out);
    prev_v = bi.Valid;
  endtask

  task automatic step(bit l, logic [7:0] d, bit e, bit a);
    drive(l, d, e, a);
    tick();
  endtask

  task automatic do_reset();
    bi.E = 1'b0; bi.L = 1'b0; bi.Ack = 1'b0; bi.In_Bus = '0;
    clr = 1'b1;
    #1;
    model_reset();
    chk("rst_valid", 32'(bi.Valid), 32'h0);
    chk("rst_data", 32'(bi.Data_Out), 32'h0);
    chk("rst_bus_off", 32'(out_bus), 32'hFF);
    bi.E = 1'b1;
    #1;
    chk("rst_status", 32'(out_bus), 32'h20);
    repeat (2) @(negedge clk);
    bi.E = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    do_reset();

    // Single byte: minimum latency and release on Ack
    step(1, 8'h3C, 0, 0);
    step(0, 8'h00, 0, 0);
    chk("lat_valid", 32'(bi.Valid), 32'h1);
    chk("lat_data", 32'(bi.Data_Out), 32'h3C);
    step(0, 8'h00, 0, 1);
    chk("ack_drop", 32'(bi.Valid), 32'h0);
    chk("data_hold", 32'(bi.Data_Out), 32'h3C);
    step(0, 8'h00, 0, 0);

    // Asynchronous clear while a byte is presented
    step(1, 8'hA5, 0, 0);
    step(1, 8'h5A, 0, 0);
    @(negedge clk);
    #2;
    bi.E = 1'b1;
    clr = 1'b1;
    #1;
    chk("aclr_valid", 32'(bi.Valid), 32'h0);
    chk("aclr_data", 32'(bi.Data_Out), 32'h0);
    chk("aclr_status", 32'(out_bus), 32'h20);
    model_reset();
    @(negedge clk);
    bi.E = 1'b0; bi.L = 1'b0;
    clr = 1'b0;

    // Fill, overflow, long Ack hold, status readback
    for (int i = 1; i <= 5; i++) step(1, 8'(i), 0, 0);
    step(1, 8'h06, 0, 0);
    repeat (4) step(0, 8'h00, 0, 1);
    chk("rel_hold", 32'(bi.Valid), 32'h0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    drive(0, 8'h00, 1, 0);
    chk("status_92", 32'(out_bus), 32'h92);
    tick();
    drive(0, 8'h00, 1, 0);
    chk("status_12", 32'(out_bus), 32'h12);
    tick();
    drive(0, 8'h00, 0, 0);
    chk("status_off", 32'(out_bus), 32'hFF);
    tick();
    repeat (20) step(0, 8'h00, 0, presenting);
    chk("dlv_count", 32'(delivered.size()), 32'd5);
    for (int i = 0; i < delivered.size() && i < 5; i++)
      chk("dlv_order", 32'(delivered[i]), 32'(i + 1));

    // Randomized writes, status reads and device acknowledges
    do_reset();
    for (int c = 0; c < 300; c++)
      step($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 7) == 0,
           1'($urandom_range(0, 1)));
    repeat (40) step(0, 8'h00, 0, presenting);
    chk("rnd_count", 32'(delivered.size()), 32'(accepted.size()));
    for (int i = 0; i < delivered.size() && i < accepted.size(); i++)
      chk("rnd_order", 32'(delivered[i]), 32'(accepted[i]));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
